spi_master_sequencer: RTL and testbench

//  Time-shares the single FPGA SPI master engine (spi_master_sck/mosi/miso) between the NUM_DRV gate-driver chips
//  (drv_ncs) and the NUM_ADC current-sense ADCs (adc_ncs). Round-robin arbitrates requests from the host

---
 rtl/spi_master_sequencer_pkg.sv | 27 ++
 rtl/spi_master_sequencer_if.sv | 32 +++
 rtl/spi_master_sequencer_rr_arbiter.sv | 47 ++++
 rtl/spi_master_sequencer.sv | 179 +++++++++++++++++
 tb/tb_spi_master_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_sequencer_pkg.sv
// ============================================================================
// spi_master_sequencer_pkg : shared state encoding and constants for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_master_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_t;

    // Driver chip selects occupy the low target indices, ADCs follow them
    localparam int DRV_BASE           = 0;
    localparam int DATA_WIDTH_DEFAULT = 16;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_sequencer_if.sv
// ============================================================================
// spi_master_sequencer_if : requester and SPI-engine handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_master_sequencer_if
    import spi_master_sequencer_pkg::*;
#(
    parameter int NUM_TGT    = 7,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic [NUM_TGT-1:0]            req;
    logic [NUM_TGT*DATA_WIDTH-1:0] req_data;
    logic [NUM_TGT-1:0]            ack;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          m_start;
    logic [DATA_WIDTH-1:0]         m_tx;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rx;

    // slave = the sequencer; master = requesters plus the SPI engine around it
    modport slave  (input  req, req_data, m_done, m_rx,
                    output ack, rsp_data, rsp_err, m_start, m_tx);
    modport master (output req, req_data, m_done, m_rx,
                    input  ack, rsp_data, rsp_err, m_start, m_tx);

endinterface

`default_nettype wire

// File: rtl/spi_master_sequencer_rr_arbiter.sv
// ============================================================================
// spi_master_sequencer_rr_arbiter : combinational round-robin pick starting at ptr_i
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_sequencer_rr_arbiter
    import spi_master_sequencer_pkg::*;
#(
    parameter int NUM_TGT = 7,
    parameter int IDX_W   = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic [NUM_TGT-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_TGT-1:0] grant_oh_o
);

    localparam int CAND_W = IDX_W + 1;

    logic [CAND_W-1:0] cand;

    // ptr_i is the highest-priority index; the search wraps once around the ring
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            cand = {1'b0, ptr_i} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_TGT)) begin
                cand = cand - CAND_W'(NUM_TGT);
            end
            if (!grant_valid_o && req_i[cand[IDX_W-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand[IDX_W-1:0];
            end
        end
        grant_oh_o = '0;
        if (grant_valid_o) begin
            grant_oh_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_sequencer.sv
// ============================================================================
// spi_master_sequencer : shares one SPI engine between gate drivers and ADCs
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_sequencer
    import spi_master_sequencer_pkg::*;
#(
    parameter int NUM_DRV    = 5,
    parameter int NUM_ADC    = 2,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4,
    parameter int CS_IDLE    = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    spi_master_sequencer_if.slave bus,
    output logic [NUM_DRV-1:0]   drv_ncs,
    output logic [NUM_ADC-1:0]   adc_ncs,
    output logic                 active
);

    localparam int NUM_TGT  = NUM_DRV + NUM_ADC;
    localparam int ADC_BASE = DRV_BASE + NUM_DRV;
    localparam int IDX_W    = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int CNT_MAX  = max_of(max_of(CS_SETUP, CS_HOLD), max_of(CS_IDLE, TIMEOUT));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TGT - 1);

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  err_q, err_d;
    logic [NUM_TGT-1:0]    ncs_q, ncs_d;
    logic [NUM_TGT-1:0]    ack_q, ack_d;
    logic                  start_q, start_d;

    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_TGT-1:0]    grant_oh;
    logic [DATA_WIDTH-1:0] slice [NUM_TGT];

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_slice
        assign slice[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    spi_master_sequencer_rr_arbiter #(
        .NUM_TGT (NUM_TGT),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i         (bus.req),
        .ptr_i         (ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .grant_oh_o    (grant_oh)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        err_d   = err_q;
        ncs_d   = ncs_q;
        ack_d   = '0;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    idx_d   = grant_idx;
                    tx_d    = slice[grant_idx];
                    ncs_d   = ~grant_oh;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_XFER: begin
                // A completion in the last allowed cycle beats the timeout
                if (bus.m_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rx_d    = bus.m_rx;
                    err_d   = 1'b0;
                end else if (cnt_q == XFER_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rx_d    = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                    ncs_d        = '1;
                    ack_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ncs_d   = '1;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            ncs_q   <= '1;
            ack_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            ncs_q   <= ncs_d;
            ack_q   <= ack_d;
            start_q <= start_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rsp_data = rx_q;
    assign bus.rsp_err  = err_q;
    assign bus.m_start  = start_q;
    assign bus.m_tx     = tx_q;
    assign drv_ncs      = ncs_q[DRV_BASE +: NUM_DRV];
    assign adc_ncs      = ncs_q[ADC_BASE +: NUM_ADC];
    assign active       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_master_sequencer.sv
// ============================================================================
// tb_spi_master_sequencer : timestamp-model bench for the SPI sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_sequencer;

    localparam int NUM_DRV  = 5;
    localparam int NUM_ADC  = 2;
    localparam int NUM_TGT  = 7;
    localparam int DW       = 16;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_IDLE  = 8;
    localparam int TIMEOUT  = 1023;

    logic sysclk;
    logic rst_n;
    logic [NUM_DRV-1:0] drv_ncs;
    logic [NUM_ADC-1:0] adc_ncs;
    logic active;

    spi_master_sequencer_if #(.NUM_TGT(NUM_TGT), .DATA_WIDTH(DW)) bus ();

    spi_master_sequencer #(
        .NUM_DRV(NUM_DRV), .NUM_ADC(NUM_ADC), .DATA_WIDTH(DW),
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .bus     (bus),
        .drv_ncs (drv_ncs),
        .adc_ncs (adc_ncs),
        .active  (active)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // requester / engine environment
    logic [NUM_TGT-1:0] want;
    logic [DW-1:0]      tx_word [NUM_TGT];
    bit                 auto_drop;
    bit                 eng_hang;
    bit                 eng_rand;
    bit                 eng_fixed;
    bit                 stray_en;
    int                 eng_lat;
    logic [DW-1:0]      eng_word;
    int                 done_at;
    int                 ack_log [$];
    int                 last_ack_cyc;
    logic [DW-1:0]      last_rsp;
    logic               last_err;
    logic [NUM_ADC-1:0] last_adc;

    // model: one transaction described by its timestamps
    bit            have;
    bit            done_known;
    int            s_c, x_c, d_c, a_c, idle_at;
    int            m_tgt;
    int            ptr;
    logic [DW-1:0] m_word, m_rx_v;
    logic          m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        bus.req = want;
        for (int i = 0; i < NUM_TGT; i++) bus.req_data[i*DW +: DW] = tx_word[i];
    endtask

    task automatic model_update();
        int t;
        if (!rst_n) return;
        if (have && !done_known && cyc >= x_c && cyc <= x_c + TIMEOUT - 1) begin
            if (bus.m_done) begin
                d_c = cyc; m_rx_v = bus.m_rx; m_err = 1'b0; done_known = 1'b1;
            end else if (cyc == x_c + TIMEOUT - 1) begin
                d_c = cyc; m_rx_v = '0; m_err = 1'b1; done_known = 1'b1;
            end
            if (done_known) begin
                a_c     = d_c + 1 + CS_HOLD;
                idle_at = a_c + CS_IDLE;
                ptr     = (m_tgt + 1) % NUM_TGT;
            end
        end
        if ((!have || done_known) && cyc >= idle_at && bus.req != '0) begin
            for (int k = 0; k < NUM_TGT; k++) begin
                t = (ptr + k) % NUM_TGT;
                if (bus.req[t]) begin
                    have = 1'b1; done_known = 1'b0; m_tgt = t;
                    s_c = cyc + 1; x_c = s_c + CS_SETUP;
                    m_word = bus.req_data[t*DW +: DW];
                    break;
                end
            end
        end
    endtask

    task automatic compare();
        logic [NUM_TGT-1:0] e_ncs, e_ack;
        bit in_sel;
        in_sel = have && cyc >= s_c && (!done_known || cyc < a_c);
        e_ncs = '1;
        if (in_sel) e_ncs[m_tgt] = 1'b0;
        e_ack = '0;
        if (have && done_known && cyc == a_c) e_ack[m_tgt] = 1'b1;
        chk("ncs", {adc_ncs, drv_ncs}, e_ncs);
        chk("m_start", bus.m_start, have && cyc == x_c);
        chk("ack", bus.ack, e_ack);
        chk("active", active, have && cyc >= s_c && (!done_known || cyc < idle_at));
        if (have && cyc >= x_c && (!done_known || cyc <= d_c)) chk("m_tx", bus.m_tx, m_word);
        if (e_ack != '0) begin
            chk("rsp_data", bus.rsp_data, m_rx_v);
            chk("rsp_err", bus.rsp_err, m_err);
        end
        for (int i = 0; i < NUM_TGT; i++) begin
            if (bus.ack[i]) begin
                ack_log.push_back(i);
                last_ack_cyc = cyc; last_rsp = bus.rsp_data;
                last_err = bus.rsp_err; last_adc = adc_ncs;
                if (auto_drop) want[i] = 1'b0;
                break;
            end
        end
    endtask

    task automatic engine();
        bus.m_done = 1'b0;
        bus.m_rx   = DW'($urandom);
        if (bus.m_start && !eng_hang) begin
            done_at  = cyc + (eng_rand ? int'($urandom_range(1, 40)) : eng_lat);
            eng_word = eng_fixed ? 16'hBEEF : DW'($urandom);
        end
        if (cyc == done_at) begin
            bus.m_done = 1'b1; bus.m_rx = eng_word; done_at = -1;
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
            bus.m_done = 1'b1;
        end
    endtask

    task automatic step();
        drive();
        model_update();
        @(negedge sysclk);
        cyc++;
        compare();
        engine();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b = 0;
        while (ack_log.size() < n && b < budget) begin
            step(); b++;
        end
        if (ack_log.size() < n) chk("ack_wait_timeout", 64'(ack_log.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        step();
        while (active && b < budget) begin
            step(); b++;
        end
        if (active) chk("idle_wait_timeout", 64'(active), 64'd0);
    endtask

    task automatic model_reset();
        have = 1'b0; done_known = 1'b0; ptr = 0; idle_at = 0; done_at = -1;
    endtask

    // Assert reset mid-cycle, confirm the selects drop asynchronously, release after a negedge
    task automatic reset_now(input logic [NUM_TGT-1:0] want_after);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drv_ncs", drv_ncs, 5'b11111);
        chk("async_adc_ncs", adc_ncs, 2'b11);
        chk("async_active", active, 1'b0);
        model_reset();
        eng_hang = 1'b0;
        want = want_after;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        want = '0; auto_drop = 1'b1; eng_hang = 1'b0; eng_rand = 1'b0;
        eng_fixed = 1'b1; stray_en = 1'b0; eng_lat = 20; eng_word = '0;
        for (int i = 0; i < NUM_TGT; i++) tx_word[i] = '0;
        bus.m_done = 1'b0; bus.m_rx = '0;
        model_reset();
        drive();
        repeat (3) @(negedge sysclk);
        chk("rst_drv_ncs", drv_ncs, 5'b11111);
        chk("rst_adc_ncs", adc_ncs, 2'b11);
        chk("rst_ack", bus.ack, 7'd0);
        chk("rst_rsp_data", bus.rsp_data, 16'h0000);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_m_start", bus.m_start, 1'b0);
        chk("rst_m_tx", bus.m_tx, 16'h0000);
        chk("rst_active", active, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();

        // single driver transfer with literal timing pins
        n0 = cyc;
        tx_word[2] = 16'h1234;
        want[2] = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 1)  chk("t1_drv_ncs", drv_ncs, 5'b11011);
            if (k == 4)  chk("t1_no_start_early", bus.m_start, 1'b0);
            if (k == 5)  chk("t1_m_start", bus.m_start, 1'b1);
            if (k == 5)  chk("t1_m_tx", bus.m_tx, 16'h1234);
            if (k == 29) chk("t1_no_ack_early", bus.ack, 7'd0);
            if (k == 30) chk("t1_ack", bus.ack, 7'b0000100);
            if (k == 30) chk("t1_rsp_data", bus.rsp_data, 16'hBEEF);
            if (k == 30) chk("t1_rsp_err", bus.rsp_err, 1'b0);
        end
        if (cyc != n0 + 31) chk("t1_cycle_count", 64'(cyc), 64'(n0 + 31));
        wait_idle(50);

        // everyone requesting from reset: strict rotation
        eng_fixed = 1'b0; eng_rand = 1'b1; auto_drop = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) tx_word[i] = DW'($urandom);
        reset_now('1);
        ack_log.delete();
        wait_acks(8, 1200);
        want = '0;
        if (ack_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("t2_order", 64'(ack_log[i]), 64'(i % NUM_TGT));
        end
        wait_idle(100);

        // after 3 completes, 5 outranks 1
        auto_drop = 1'b1;
        ack_log.delete();
        want[3] = 1'b1;
        wait_acks(1, 200);
        ack_log.delete();
        want[1] = 1'b1; want[5] = 1'b1;
        wait_acks(2, 300);
        if (ack_log.size() >= 2) begin
            chk("t3_first", 64'(ack_log[0]), 64'd5);
            chk("t3_second", 64'(ack_log[1]), 64'd1);
        end
        wait_idle(100);

        // ADC 1 with a silent engine: timeout path
        eng_hang = 1'b1; stray_en = 1'b0;
        ack_log.delete();
        n0 = cyc;
        want[6] = 1'b1;
        wait_acks(1, 1200);
        if (ack_log.size() >= 1) begin
            chk("t4_ack_idx", 64'(ack_log[0]), 64'd6);
            chk("t4_ack_cycle", 64'(last_ack_cyc), 64'(n0 + 1 + CS_SETUP + TIMEOUT + CS_HOLD));
            chk("t4_rsp_err", last_err, 1'b1);
            chk("t4_rsp_data", last_rsp, 16'h0000);
            chk("t4_adc_ncs", last_adc, 2'b11);
        end
        wait_idle(100);

        // reset in the middle of target 4's transfer
        ack_log.delete();
        want[4] = 1'b1;
        begin
            int b = 0;
            while (!bus.m_start && b < 100) begin step(); b++; end
            chk("t5_reached_xfer", bus.m_start, 1'b1);
        end
        repeat (5) step();
        reset_now(7'b0010001);
        chk("t5_no_ack", 64'(ack_log.size()), 64'd0);
        wait_acks(2, 300);
        if (ack_log.size() >= 2) begin
            chk("t5_first", 64'(ack_log[0]), 64'd0);
            chk("t5_second", 64'(ack_log[1]), 64'd4);
        end
        wait_idle(100);

        // stray m_done in IDLE and SETUP, request withdrawn during SETUP
        ack_log.delete();
        bus.m_done = 1'b1;
        step();
        want[1] = 1'b1;
        step();
        want[1] = 1'b0;
        step();
        bus.m_done = 1'b1;
        wait_acks(1, 200);
        if (ack_log.size() >= 1) chk("t6_ack_idx", 64'(ack_log[0]), 64'd1);
        wait_idle(100);

        // randomized traffic
        stray_en = 1'b1; eng_rand = 1'b1; eng_hang = 1'b0; auto_drop = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                int t = int'($urandom_range(0, NUM_TGT - 1));
                want[t] = 1'b1;
                tx_word[t] = DW'($urandom);
            end
            if ($urandom_range(0, 49) == 0) want[$urandom_range(0, NUM_TGT - 1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) tx_word[$urandom_range(0, NUM_TGT - 1)] = DW'($urandom);
            step();
        end
        want = '0; stray_en = 1'b0;
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
